// File: rtl/blast_unit.sv
// blast_unit: consumer side of the bomb detonation interface.
// Holds up to NUM_BLASTS cross-shaped explosions, each alive for BLAST_CYCLES
// clocks. It flags pixels that fall inside a blast and reports when the
// player's box is caught in one.
// Optional build macro BLAST_HIT_STICKY_EN: player_hit becomes a level that
// sets on the first overlap and holds until reset.
// All geometry is evaluated in 12-bit signed arithmetic, so arms that reach
// past 0 or 1023 are clipped instead of wrapping.

module blast_unit #(
  parameter int NUM_BLASTS   = 6,
  parameter int BLAST_CYCLES = 50000000,
  parameter int RANGE        = 2,
  parameter int TILE         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       det_valid,
  input  logic [9:0] det_x,
  input  logic [9:0] det_y,
  input  logic [9:0] v_x,
  input  logic [9:0] v_y,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  output logic       blast_on,
  output logic       player_hit,
  output logic [3:0] active_count,
  output logic       det_drop
);

  localparam int TW = $clog2(BLAST_CYCLES);
  localparam logic [TW-1:0]        TIMER_LAST = TW'(BLAST_CYCLES - 1);
  localparam logic [TW-1:0]        TIMER_ONE  = TW'(1);
  localparam logic signed [11:0]   ARM        = 12'(RANGE * TILE);
  localparam logic signed [11:0]   SPAN       = 12'(TILE - 1);

  // Zero-extend a 10-bit screen coordinate into the signed geometry domain.
  function automatic logic signed [11:0] to_s12(input logic [9:0] c);
    return $signed({2'b00, c});
  endfunction

  // Inclusive 1-D interval overlap: [a_lo,a_hi] against [b_lo,b_hi].
  function automatic logic span_ovl(input logic signed [11:0] a_lo,
                                    input logic signed [11:0] a_hi,
                                    input logic signed [11:0] b_lo,
                                    input logic signed [11:0] b_hi);
    return (a_lo <= b_hi) && (a_hi >= b_lo);
  endfunction

  // Pixel test against both arms of a cross centred on tile (cx,cy).
  function automatic logic pix_in(input logic [9:0] cx, input logic [9:0] cy,
                                  input logic [9:0] px, input logic [9:0] py);
    logic signed [11:0] sx, sy, x, y;
    logic h_arm, v_arm;
    sx = to_s12(cx);
    sy = to_s12(cy);
    x  = to_s12(px);
    y  = to_s12(py);
    h_arm = span_ovl(x, x, sx - ARM, sx + ARM + SPAN) && span_ovl(y, y, sy, sy + SPAN);
    v_arm = span_ovl(x, x, sx, sx + SPAN) && span_ovl(y, y, sy - ARM, sy + ARM + SPAN);
    return h_arm || v_arm;
  endfunction

  // TILE x TILE box test against both arms of a cross centred on (cx,cy).
  function automatic logic box_in(input logic [9:0] cx, input logic [9:0] cy,
                                  input logic [9:0] bx, input logic [9:0] by);
    logic signed [11:0] sx, sy, x, y;
    logic h_arm, v_arm;
    sx = to_s12(cx);
    sy = to_s12(cy);
    x  = to_s12(bx);
    y  = to_s12(by);
    h_arm = span_ovl(x, x + SPAN, sx - ARM, sx + ARM + SPAN) &&
            span_ovl(y, y + SPAN, sy, sy + SPAN);
    v_arm = span_ovl(x, x + SPAN, sx, sx + SPAN) &&
            span_ovl(y, y + SPAN, sy - ARM, sy + ARM + SPAN);
    return h_arm || v_arm;
  endfunction

  // Slot state
  logic [NUM_BLASTS-1:0] r_valid;
  logic [NUM_BLASTS-1:0] r_hit_done;
  logic [9:0]            r_cx    [NUM_BLASTS];
  logic [9:0]            r_cy    [NUM_BLASTS];
  logic [TW-1:0]         r_timer [NUM_BLASTS];

  // Output registers
  logic       r_blast_on;
  logic       r_player_hit;
  logic       r_det_drop;
  logic [3:0] r_active_count;

  // Combinational helpers
  logic [NUM_BLASTS-1:0] w_alloc;
  logic                  w_found;
  logic                  w_any_free;
  logic [NUM_BLASTS-1:0] w_valid_next;
  logic [NUM_BLASTS-1:0] w_pix_in;
  logic [NUM_BLASTS-1:0] w_ovl;
  logic [NUM_BLASTS-1:0] w_new_hit;
  logic [3:0]            w_count_next;

  // Pick the lowest slot that is free at the start of this cycle; an
  // expiring slot is still valid here, so it is never reused the same cycle.
  always_comb begin
    w_alloc = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_BLASTS; i++) begin
      if (!r_valid[i] && !w_found) begin
        w_alloc[i] = det_valid;
        w_found    = 1'b1;
      end else begin
        w_alloc[i] = 1'b0;
      end
    end
    w_any_free = ~(&r_valid);
  end

  // Per-slot geometry, hit qualification and next-cycle occupancy.
  always_comb begin
    w_pix_in     = '0;
    w_ovl        = '0;
    w_valid_next = '0;
    w_count_next = 4'd0;
    for (int i = 0; i < NUM_BLASTS; i++) begin
      w_pix_in[i] = r_valid[i] && pix_in(r_cx[i], r_cy[i], v_x, v_y);
      w_ovl[i]    = r_valid[i] && box_in(r_cx[i], r_cy[i], b_x, b_y);
      if (r_valid[i]) begin
        w_valid_next[i] = (r_timer[i] != TIMER_LAST);
      end else begin
        w_valid_next[i] = w_alloc[i];
      end
      w_count_next = w_count_next + {3'b000, w_valid_next[i]};
    end
    w_new_hit = w_ovl & ~r_hit_done;
  end

  // Slot lifecycle: allocate, age, expire, and latch the first player hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= '0;
      r_hit_done <= '0;
      for (int i = 0; i < NUM_BLASTS; i++) begin
        r_cx[i]    <= 10'd0;
        r_cy[i]    <= 10'd0;
        r_timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BLASTS; i++) begin
        if (r_valid[i]) begin
          if (r_timer[i] == TIMER_LAST) begin
            r_valid[i] <= 1'b0;
            r_timer[i] <= '0;
          end else begin
            r_timer[i] <= r_timer[i] + TIMER_ONE;
          end
          if (w_new_hit[i]) begin
            r_hit_done[i] <= 1'b1;
          end
        end else if (w_alloc[i]) begin
          r_valid[i]    <= 1'b1;
          r_cx[i]       <= det_x;
          r_cy[i]       <= det_y;
          r_timer[i]    <= '0;
          r_hit_done[i] <= 1'b0;
        end
      end
    end
  end

  // Registered outputs: pixel flag, drop pulse, occupancy and player hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blast_on     <= 1'b0;
      r_det_drop     <= 1'b0;
      r_active_count <= 4'd0;
      r_player_hit   <= 1'b0;
    end else begin
      r_blast_on     <= |w_pix_in;
      r_det_drop     <= det_valid && !w_any_free;
      r_active_count <= w_count_next;
`ifdef BLAST_HIT_STICKY_EN
      r_player_hit   <= r_player_hit || (|w_ovl);
`else
      r_player_hit   <= |w_new_hit;
`endif
    end
  end

  assign blast_on     = r_blast_on;
  assign player_hit   = r_player_hit;
  assign active_count = r_active_count;
  assign det_drop     = r_det_drop;

endmodule

// File: tb/tb_blast_unit.sv
// Directed testbench for blast_unit with BLAST_CYCLES=8, NUM_BLASTS=2,
// RANGE=2, TILE=16. Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point, before the next edge.

module tb_blast_unit;

  logic       clk;
  logic       reset;
  logic       det_valid;
  logic [9:0] det_x, det_y, v_x, v_y, b_x, b_y;
  logic       blast_on, player_hit, det_drop;
  logic [3:0] active_count;

  int n_checks = 0;
  int n_fail   = 0;

  int sw_x [7] = '{68, 67, 147, 148, 100, 115, 120};
  int sw_y [7] = '{100, 100, 115, 100, 68, 147, 120};
  int sw_e [7] = '{1, 0, 1, 0, 1, 1, 0};
  int c0_x [4] = '{0, 47, 48, 1000};
  int c0_y [4] = '{47, 15, 0, 0};
  int c0_e [4] = '{1, 1, 0, 0};

  blast_unit #(
    .NUM_BLASTS(2), .BLAST_CYCLES(8), .RANGE(2), .TILE(16)
  ) dut (
    .clk(clk), .reset(reset), .det_valid(det_valid),
    .det_x(det_x), .det_y(det_y), .v_x(v_x), .v_y(v_y),
    .b_x(b_x), .b_y(b_y), .blast_on(blast_on), .player_hit(player_hit),
    .active_count(active_count), .det_drop(det_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; det_valid = 1'b0;
    det_x = 10'd0; det_y = 10'd0; v_x = 10'd0; v_y = 10'd0;
    b_x = 10'd900; b_y = 10'd900;
    idle(2);
    reset = 1'b0;
    n_checks++;
    if (active_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", active_count); end
    n_checks++;
    if (blast_on !== 1'b0 || player_hit !== 1'b0 || det_drop !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs got %b%b%b want 000", blast_on, player_hit, det_drop);
    end
  endtask

  task automatic test_lifetime();
    det_x = 10'd100; det_y = 10'd100; det_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      det_valid = 1'b0;
      n_checks++;
      if (active_count !== ((k <= 8) ? 4'd1 : 4'd0)) begin
        n_fail++; $display("FAIL lifetime_count cycle %0d got %0d want %0d", k, active_count, (k <= 8) ? 1 : 0);
      end
      n_checks++;
      if (det_drop !== 1'b0) begin n_fail++; $display("FAIL lifetime_drop cycle %0d got 1 want 0", k); end
    end
  endtask

  task automatic test_blast_sweep();
    det_x = 10'd100; det_y = 10'd100; det_valid = 1'b1;
    tick();
    det_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      v_x = 10'(sw_x[i]); v_y = 10'(sw_y[i]);
      tick();
      n_checks++;
      if (blast_on !== 1'(sw_e[i])) begin
        n_fail++; $display("FAIL sweep v=(%0d,%0d) got %b want %0d", sw_x[i], sw_y[i], blast_on, sw_e[i]);
      end
    end
    idle(10);
  endtask

  task automatic test_corner();
    det_x = 10'd0; det_y = 10'd0; det_valid = 1'b1;
    tick();
    det_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v_x = 10'(c0_x[i]); v_y = 10'(c0_y[i]);
      tick();
      n_checks++;
      if (blast_on !== 1'(c0_e[i])) begin
        n_fail++; $display("FAIL corner v=(%0d,%0d) got %b want %0d", c0_x[i], c0_y[i], blast_on, c0_e[i]);
      end
    end
    idle(10);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_cnt [3];
    logic       exp_drp [3];
    exp_cnt[0] = 4'd1; exp_cnt[1] = 4'd2; exp_cnt[2] = 4'd2;
    exp_drp[0] = 1'b0; exp_drp[1] = 1'b0; exp_drp[2] = 1'b1;
    det_x = 10'd400; det_y = 10'd400; det_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (active_count !== exp_cnt[k] || det_drop !== exp_drp[k]) begin
        n_fail++; $display("FAIL b2b event %0d got cnt=%0d drop=%b want cnt=%0d drop=%b",
                           k, active_count, det_drop, exp_cnt[k], exp_drp[k]);
      end
    end
    det_valid = 1'b0;
    tick();
    n_checks++;
    if (det_drop !== 1'b0) begin n_fail++; $display("FAIL b2b_drop_clear got 1 want 0"); end
    idle(10);
  endtask

  task automatic test_expire_collision();
    det_x = 10'd500; det_y = 10'd500; det_valid = 1'b1;
    idle(2);
    det_valid = 1'b0;
    idle(6);
    det_x = 10'd300; det_y = 10'd300; det_valid = 1'b1;
    tick();
    n_checks++;
    if (det_drop !== 1'b1 || active_count !== 4'd1) begin
      n_fail++; $display("FAIL collide_drop got drop=%b cnt=%0d want drop=1 cnt=1", det_drop, active_count);
    end
    tick();
    det_valid = 1'b0;
    n_checks++;
    if (det_drop !== 1'b0 || active_count !== 4'd1) begin
      n_fail++; $display("FAIL collide_retry got drop=%b cnt=%0d want drop=0 cnt=1", det_drop, active_count);
    end
    v_x = 10'd300; v_y = 10'd300;
    tick();
    n_checks++;
    if (blast_on !== 1'b1) begin n_fail++; $display("FAIL collide_slot_pos got 0 want 1"); end
    idle(10);
  endtask

  task automatic test_player_hit();
    int pulses;
    b_x = 10'd132; b_y = 10'd100;
    det_x = 10'd100; det_y = 10'd100; det_valid = 1'b1;
    tick();
    det_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (player_hit === 1'b1) pulses++;
    end
`ifdef BLAST_HIT_STICKY_EN
    n_checks++;
    if (player_hit !== 1'b1) begin n_fail++; $display("FAIL hit_sticky got %b want 1", player_hit); end
`else
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL hit_pulses got %0d want 1", pulses); end
`endif
    b_x = 10'd149; b_y = 10'd100;
    det_valid = 1'b1;
    tick();
    det_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (player_hit === 1'b1) pulses++;
    end
`ifdef BLAST_HIT_STICKY_EN
    n_checks++;
    if (pulses != 12) begin n_fail++; $display("FAIL hit_sticky_hold got %0d want 12", pulses); end
`else
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL hit_miss_pulses got %0d want 0", pulses); end
`endif
    b_x = 10'd900; b_y = 10'd900;
  endtask

  task automatic test_reset_mid_blast();
    det_x = 10'd200; det_y = 10'd200; det_valid = 1'b1;
    tick();
    det_valid = 1'b0;
    v_x = 10'd200; v_y = 10'd200;
    tick();
    n_checks++;
    if (blast_on !== 1'b1) begin n_fail++; $display("FAIL mid_pre_blast got 0 want 1"); end
    reset = 1'b1;
    tick();
    n_checks++;
    if (active_count !== 4'd0 || blast_on !== 1'b0 || player_hit !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got cnt=%0d on=%b hit=%b want 0 0 0", active_count, blast_on, player_hit);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (active_count !== 4'd0 || blast_on !== 1'b0) begin
      n_fail++; $display("FAIL mid_after got cnt=%0d on=%b want 0 0", active_count, blast_on);
    end
  endtask

  initial begin
    test_reset();
    test_lifetime();
    test_blast_sweep();
    test_corner();
    test_back_to_back();
    test_expire_collision();
    test_player_hit();
    test_reset_mid_blast();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
